// File: rtl/ofs_fim_pcie_ss_txreq_guard.sv
// Protocol guard for the PCIe SS txreq AXI-S path: forwards only single-beat DM MRd32/MRd64/Intr
// headers through a registered stage with a 2-entry skid buffer; drops, counts and flags everything else.
module ofs_fim_pcie_ss_txreq_guard #(
  parameter int TDATA_W = 256,
  parameter int TUSER_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic               fim_clk,
  input  logic               fim_rst,
  input  logic               in_tvalid,
  output logic               in_tready,
  input  logic [TDATA_W-1:0] in_tdata,
  input  logic [TUSER_W-1:0] in_tuser,
  input  logic               in_tlast,
  output logic               out_tvalid,
  input  logic               out_tready,
  output logic [TDATA_W-1:0] out_tdata,
  output logic [TUSER_W-1:0] out_tuser,
  output logic               out_tlast,
  input  logic               err_clr,
  output logic               err_sticky,
  output logic [1:0]         err_code,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  typedef enum logic {ST_SOP, ST_DROP} state_t;

  state_t             state;
  logic               rdy_q;
  logic               acc;
  logic [7:0]         fmt_type;
  logic [1:0]         chk_code;
  logic [1:0]         drop_code;
  logic               legal;
  logic               fwd;
  logic               drop;
  logic               ld;
  logic               pop;
  logic               push;
  logic [1:0]         sk_cnt;
  logic [1:0]         sk_cnt_nxt;
  logic [TDATA_W-1:0] sk_data [2];
  logic [TUSER_W-1:0] sk_user [2];

  assign in_tready = rdy_q;
  assign acc       = in_tvalid & rdy_q;
  assign fmt_type  = in_tdata[31:24];

  always_comb begin
    chk_code = 2'b00;
    if (!in_tuser[0])
      chk_code = 2'b01;
    else if (!in_tlast)
      chk_code = 2'b10;
    else if (!((fmt_type == 8'h00) || (fmt_type == 8'h20) || (fmt_type == 8'h30)))
      chk_code = 2'b11;
  end

  // Continuation beats of a dropped packet are reported as multi-beat if they end up being the first capture.
  assign drop_code = (state == ST_DROP) ? 2'b10 : chk_code;
  assign legal     = (state == ST_SOP) && (chk_code == 2'b00);
  assign fwd       = acc & legal;
  assign drop      = acc & ~legal;

  // Output register loads when empty or being consumed; skid head has priority over the input.
  assign ld   = ~out_tvalid | out_tready;
  assign pop  = ld & (sk_cnt != 2'd0);
  assign push = fwd & ~(ld & (sk_cnt == 2'd0));

  always_comb begin
    sk_cnt_nxt = sk_cnt;
    if (push && !pop)
      sk_cnt_nxt = sk_cnt + 2'd1;
    else if (pop && !push)
      sk_cnt_nxt = sk_cnt - 2'd1;
  end

  always_ff @(posedge fim_clk or posedge fim_rst) begin
    if (fim_rst) begin
      rdy_q      <= 1'b0;
      sk_cnt     <= 2'd0;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tuser  <= '0;
      out_tlast  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        sk_data[i] <= '0;
        sk_user[i] <= '0;
      end
    end else begin
      rdy_q  <= (sk_cnt_nxt != 2'd2);
      sk_cnt <= sk_cnt_nxt;
      if (ld) begin
        if (sk_cnt != 2'd0) begin
          out_tvalid <= 1'b1;
          out_tdata  <= sk_data[0];
          out_tuser  <= sk_user[0];
          out_tlast  <= 1'b1;
        end else if (fwd) begin
          out_tvalid <= 1'b1;
          out_tdata  <= in_tdata;
          out_tuser  <= in_tuser;
          out_tlast  <= 1'b1;
        end else begin
          out_tvalid <= 1'b0;
        end
      end
      // A push concurrent with a pop only happens with one entry held, so it refills the head.
      if (pop) begin
        sk_data[0] <= push ? in_tdata : sk_data[1];
        sk_user[0] <= push ? in_tuser : sk_user[1];
      end else if (push) begin
        if (sk_cnt == 2'd0) begin
          sk_data[0] <= in_tdata;
          sk_user[0] <= in_tuser;
        end else begin
          sk_data[1] <= in_tdata;
          sk_user[1] <= in_tuser;
        end
      end
    end
  end

  always_ff @(posedge fim_clk or posedge fim_rst) begin
    if (fim_rst) begin
      state <= ST_SOP;
    end else begin
      case (state)
        ST_SOP:  if (drop && !in_tlast) state <= ST_DROP;
        ST_DROP: if (acc && in_tlast)   state <= ST_SOP;
        default: state <= ST_SOP;
      endcase
    end
  end

  always_ff @(posedge fim_clk or posedge fim_rst) begin
    if (fim_rst) begin
      err_sticky <= 1'b0;
      err_code   <= 2'b00;
      pass_cnt   <= '0;
      drop_cnt   <= '0;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
      err_code   <= 2'b00;
      pass_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      if (drop && !err_sticky) begin
        err_sticky <= 1'b1;
        err_code   <= drop_code;
      end
      if (fwd && (pass_cnt != '1))
        pass_cnt <= pass_cnt + 1'b1;
      if (drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ofs_fim_pcie_ss_txreq_guard.sv
// Directed bench for the txreq guard; a second instance with narrow counters exercises saturation.
module tb_ofs_fim_pcie_ss_txreq_guard;

  localparam int TDATA_W = 256;
  localparam int TUSER_W = 10;
  localparam int CNT_W   = 16;

  logic               fim_clk = 1'b0;
  logic               fim_rst = 1'b0;
  logic               in_tvalid = 1'b0;
  logic               in_tready;
  logic [TDATA_W-1:0] in_tdata = '0;
  logic [TUSER_W-1:0] in_tuser = '0;
  logic               in_tlast = 1'b0;
  logic               out_tvalid;
  logic               out_tready = 1'b1;
  logic [TDATA_W-1:0] out_tdata;
  logic [TUSER_W-1:0] out_tuser;
  logic               out_tlast;
  logic               err_clr = 1'b0;
  logic               err_sticky;
  logic [1:0]         err_code;
  logic [CNT_W-1:0]   pass_cnt;
  logic [CNT_W-1:0]   drop_cnt;

  logic               s_in_tready, s_out_tvalid, s_out_tlast, s_err_sticky;
  logic [TDATA_W-1:0] s_out_tdata;
  logic [TUSER_W-1:0] s_out_tuser;
  logic [1:0]         s_err_code;
  logic [2:0]         s_pass_cnt, s_drop_cnt;

  ofs_fim_pcie_ss_txreq_guard #(.TDATA_W(TDATA_W), .TUSER_W(TUSER_W), .CNT_W(CNT_W)) u_dut (
    .fim_clk(fim_clk), .fim_rst(fim_rst),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tlast(in_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tuser(out_tuser),
    .out_tlast(out_tlast), .err_clr(err_clr), .err_sticky(err_sticky), .err_code(err_code),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt)
  );

  ofs_fim_pcie_ss_txreq_guard #(.TDATA_W(TDATA_W), .TUSER_W(TUSER_W), .CNT_W(3)) u_dut_sat (
    .fim_clk(fim_clk), .fim_rst(fim_rst),
    .in_tvalid(in_tvalid), .in_tready(s_in_tready), .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tlast(in_tlast),
    .out_tvalid(s_out_tvalid), .out_tready(out_tready), .out_tdata(s_out_tdata), .out_tuser(s_out_tuser),
    .out_tlast(s_out_tlast), .err_clr(err_clr), .err_sticky(s_err_sticky), .err_code(s_err_code),
    .pass_cnt(s_pass_cnt), .drop_cnt(s_drop_cnt)
  );

  always #5 fim_clk = ~fim_clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Negedge monitor: handshakes seen here complete on the following posedge.
  int unsigned  cyc = 0;
  int unsigned  stall_viol = 0;
  logic [15:0]  out_ids [$];
  int unsigned  out_cyc [$];
  int unsigned  acc_cyc [$];
  logic         prev_stall = 1'b0;
  logic [TDATA_W-1:0] prev_data = '0;

  always @(negedge fim_clk) begin
    cyc++;
    if (prev_stall && (!out_tvalid || out_tdata !== prev_data))
      stall_viol++;
    prev_stall = out_tvalid & ~out_tready;
    prev_data  = out_tdata;
    if (out_tvalid && out_tready) begin
      out_ids.push_back(out_tdata[15:0]);
      out_cyc.push_back(cyc);
    end
    if (in_tvalid && in_tready)
      acc_cyc.push_back(cyc);
  end

  task automatic clear_q();
    out_ids.delete();
    out_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic send(input logic [7:0] fmt, input logic dm, input logic last, input logic [15:0] id);
    int unsigned n;
    logic ok;
    in_tdata        = '0;
    in_tdata[31:24] = fmt;
    in_tdata[15:0]  = id;
    in_tuser        = '0;
    in_tuser[0]     = dm;
    in_tlast        = last;
    in_tvalid       = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 64) begin
      @(negedge fim_clk);
      ok = in_tready;
      n++;
      @(posedge fim_clk);
    end
    #1;
    in_tvalid = 1'b0;
    if (!ok) chk("send_timeout", 64'(n), 64'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge fim_clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge fim_clk);
    #1;
  endtask

  task automatic chk_err(input string tag, input logic st, input logic [1:0] code,
                         input logic [15:0] pc, input logic [15:0] dc);
    chk({tag, "_sticky"}, 64'(err_sticky), 64'(st));
    chk({tag, "_code"},   64'(err_code),   64'(code));
    chk({tag, "_pass"},   64'(pass_cnt),   64'(pc));
    chk({tag, "_drop"},   64'(drop_cnt),   64'(dc));
  endtask

  initial begin
    #2 fim_rst = 1'b1;
    #20;
    chk("rst_in_tready",  64'(in_tready),  64'd0);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_out_tlast",  64'(out_tlast),  64'd0);
    chk("rst_out_tdata",  64'(out_tdata[63:0]), 64'd0);
    chk_err("rst", 1'b0, 2'b00, 16'd0, 16'd0);
    @(posedge fim_clk);
    #1 fim_rst = 1'b0;
    chk("rel_in_tready_pre", 64'(in_tready), 64'd0);
    @(posedge fim_clk);
    #1;
    chk("rel_in_tready_post", 64'(in_tready), 64'd1);

    // 1: 8 back-to-back MRd64
    clear_q();
    out_tready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'h20, 1'b1, 1'b1, 16'(16'h100 + i));
    drain();
    chk("t1_count", 64'(out_ids.size()), 64'd8);
    if (out_ids.size() == 8 && acc_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t1_order", 64'(out_ids[i]), 64'(16'h100 + i));
      chk("t1_latency", 64'(out_cyc[0] - acc_cyc[0]), 64'd1);
      chk("t1_nobubble", 64'(out_cyc[7] - out_cyc[0]), 64'd7);
    end
    chk("t1_pass", 64'(pass_cnt), 64'd8);
    chk("t1_sat_pass", 64'(s_pass_cnt), 64'd7);

    // 2: stall with skid filling
    clear_q();
    out_tready = 1'b0;
    send(8'h20, 1'b1, 1'b1, 16'h200);
    send(8'h00, 1'b1, 1'b1, 16'h201);
    send(8'h30, 1'b1, 1'b1, 16'h202);
    chk("t2_ready_low", 64'(in_tready), 64'd0);
    chk("t2_out_head", 64'(out_tdata[15:0]), 64'h200);
    fork
      begin
        send(8'h20, 1'b1, 1'b1, 16'h203);
        send(8'h20, 1'b1, 1'b1, 16'h204);
      end
      begin
        repeat (5) @(posedge fim_clk);
        #1;
        chk("t2_ready_hold", 64'(in_tready), 64'd0);
        chk("t2_out_hold", 64'(out_tdata[15:0]), 64'h200);
        out_tready = 1'b1;
      end
    join
    drain();
    chk("t2_count", 64'(out_ids.size()), 64'd5);
    if (out_ids.size() == 5)
      for (int i = 0; i < 5; i++) chk("t2_order", 64'(out_ids[i]), 64'(16'h200 + i));
    chk("t2_stable", 64'(stall_viol), 64'd0);
    chk("t2_pass", 64'(pass_cnt), 64'd13);

    // 3: PU beat dropped, Intr forwarded
    pulse_clr();
    clear_q();
    send(8'h20, 1'b0, 1'b1, 16'h300);
    send(8'h30, 1'b1, 1'b1, 16'h301);
    drain();
    chk_err("t3", 1'b1, 2'b01, 16'd1, 16'd1);
    chk("t3_count", 64'(out_ids.size()), 64'd1);
    if (out_ids.size() == 1) chk("t3_id", 64'(out_ids[0]), 64'h301);

    // 4: 3-beat packet then MRd32
    pulse_clr();
    clear_q();
    send(8'h20, 1'b1, 1'b0, 16'h400);
    send(8'h20, 1'b1, 1'b0, 16'h401);
    send(8'h20, 1'b1, 1'b1, 16'h402);
    send(8'h00, 1'b1, 1'b1, 16'h403);
    drain();
    chk_err("t4", 1'b1, 2'b10, 16'd1, 16'd3);
    chk("t4_count", 64'(out_ids.size()), 64'd1);
    if (out_ids.size() == 1) chk("t4_id", 64'(out_ids[0]), 64'h403);

    // 5: MWr then non-DM MRd, code held until clear; clear coinciding with a drop
    pulse_clr();
    clear_q();
    send(8'h60, 1'b1, 1'b1, 16'h500);
    send(8'h20, 1'b0, 1'b1, 16'h501);
    drain();
    chk_err("t5_held", 1'b1, 2'b11, 16'd0, 16'd2);
    chk("t5_count", 64'(out_ids.size()), 64'd0);
    pulse_clr();
    chk_err("t5_clr", 1'b0, 2'b00, 16'd0, 16'd0);
    err_clr = 1'b1;
    send(8'h60, 1'b1, 1'b1, 16'h502);
    err_clr = 1'b0;
    chk_err("t5_coinc", 1'b0, 2'b00, 16'd0, 16'd0);
    send(8'h20, 1'b0, 1'b1, 16'h503);
    chk_err("t5_next", 1'b1, 2'b01, 16'd0, 16'd1);

    // 6: reset while in DROP with skid occupied
    pulse_clr();
    clear_q();
    out_tready = 1'b0;
    send(8'h20, 1'b1, 1'b1, 16'h600);
    send(8'h20, 1'b1, 1'b1, 16'h601);
    send(8'h20, 1'b1, 1'b0, 16'h602);
    chk_err("t6_pre", 1'b1, 2'b10, 16'd2, 16'd1);
    #2 fim_rst = 1'b1;
    #1;
    chk("t6_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("t6_in_tready",  64'(in_tready),  64'd0);
    chk("t6_out_tdata",  64'(out_tdata[63:0]), 64'd0);
    chk("t6_out_tlast",  64'(out_tlast),  64'd0);
    chk_err("t6_rst", 1'b0, 2'b00, 16'd0, 16'd0);
    repeat (2) @(posedge fim_clk);
    #1 fim_rst = 1'b0;
    out_tready = 1'b1;
    @(posedge fim_clk);
    #1;
    send(8'h30, 1'b1, 1'b1, 16'h610);
    drain();
    chk("t6_count", 64'(out_ids.size()), 64'd1);
    if (out_ids.size() == 1) chk("t6_id", 64'(out_ids[0]), 64'h610);
    chk_err("t6_post", 1'b0, 2'b00, 16'd1, 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
